alu_issue: RTL and testbench
============================

// Module: alu_issue
// PURPOSE
//  ID/EX pipeline stage directly upstream of the ALU. Latches decoded operands, immediate and ALUOp
//  from decode. Resolves RAW hazards by forwarding EX/MEM (and optionally MEM/WB) results onto A/B.
//  Supports stall (hold) and flush (bubble) from the hazard unit. Drives the ALU's A, B and ALUOp directly.
// PARAMETERS
//  W        32  datapath width (A, B, data ports)
//  RIDX_W   5   register index width; index 0 is hard-wired zero
//  OP_W     5   ALUOp width
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  rst          in   1       synchronous, active-high reset
//  stall        in   1       hold stage contents; upstream must hold its inputs
//  flush        in   1       kill stage contents (insert bubble)
//  in_valid     in   1       decode presents a valid instruction
//  in_rs_idx    in   RIDX_W  source reg 1 index
//  in_rt_idx    in   RIDX_W  source reg 2 index
//  in_rs_data   in   W       regfile read data for rs
//  in_rt_data   in   W       regfile read data for rt
//  in_imm       in   W       sign/zero-extended immediate
//  in_use_imm   in   1       1: B sources immediate; 0: B sources rt
//  in_aluop     in   OP_W    ALU operation code
//  in_rd_idx    in   RIDX_W  destination index, passed through
//  in_wr_en     in   1       destination write enable, passed through
//  mem_wr_en    in   1       EX/MEM stage will write mem_idx
//  mem_idx      in   RIDX_W  EX/MEM destination index
//  mem_data     in   W       EX/MEM result
//  wb_wr_en     in   1       MEM/WB write enable (used only with WB_FWD_EN)
//  wb_idx       in   RIDX_W  MEM/WB destination index
//  wb_data      in   W       MEM/WB write data
//  A            out  W       ALU operand A
//  B            out  W       ALU operand B
//  ALUOp        out  OP_W    ALU operation
//  out_valid    out  1       stage holds a valid instruction
//  out_rd_idx   out  RIDX_W  registered in_rd_idx
//  out_wr_en    out  1       registered in_wr_en AND out_valid
// BEHAVIOUR
//  - rst: every stage register 0 next edge; out_valid=0, ALUOp=0, A=B=0, out_wr_en=0. rst beats flush/stall.
//  - Latency 1: inputs sampled on edge N appear on outputs after edge N (no stall/flush).
//  - Priority per edge: rst > flush > stall > load. flush with stall: out_valid<=0, other regs hold.
//  - flush: out_valid<=0, out_wr_en<=0; data regs don't care, ALUOp<=0.
//  - stall: all regs hold; in_* ignored. Stalled bubble stays a bubble.
//  - Load: in_valid=0 loads a bubble (out_valid=0, out_wr_en=0).
//  - Forwarding (combinational on registered rs/rt idx and data; 0-cycle path to A/B):
//    src match MEM if mem_wr_en && mem_idx==idx && idx!=0 -> mem_data;
//    else match WB (macro on) -> wb_data; else registered data. MEM beats WB.
//  - idx==0: operand forced 0 regardless of registered data or forward sources.
//  - A = fwd(rs). B = in_use_imm(registered) ? imm : fwd(rt); imm never forwarded.
//  - Stall refresh (macro on): while stall=1 and held out_valid=1, a WB write matching a held
//    rs/rt (idx!=0) overwrites that held data reg, so it is not lost once WB retires.
//  - Forwarding is applied even when out_valid=0 (A/B are don't-care for bubbles).
// CONFIGURATION
//  WB_FWD_EN defined: MEM/WB forward path and stall refresh active.
//  WB_FWD_EN undefined: wb_* ports present but ignored; only EX/MEM forwarding; regfile must be
//  write-before-read so WB hazards resolve at decode.
// STRUCTURE
//  Package alu_pkg: aluop_t (logic [OP_W-1:0]), ridx_t, ALU op constants, ALUOP_NOP=0, REG_ZERO=0.
//  Sub-module fwd_mux: one operand's index/data + MEM/WB sources -> forwarded value;
//  instantiated twice (rs, rt).
// TESTING
//  1 rst=1 while in_valid=1,in_aluop=5'h0A -> next cycle out_valid=0,ALUOp=0,A=B=0,out_wr_en=0.
//  2 load rs=3/rt=4 data 0x11/0x22, use_imm=0, no fwd -> next cycle A=0x11,B=0x22,out_valid=1.
//  3 held rs=3; mem_wr_en=1,mem_idx=3,mem_data=0xAAAA, wb also idx=3 data 0xBBBB -> A=0xAAAA (MEM wins).
//  4 rs=0 with mem_wr_en=1,mem_idx=0,mem_data=0xFFFF -> A=0; use_imm=1,imm=0x7, rt match -> B=0x7.
//  5 stall 3 cycles, wb writes rt=4 data 0x55 during stall 1 -> B=0x55 after stall (WB_FWD_EN);
//    macro off -> B=0x22.
//  6 flush and stall same edge with valid held -> out_valid=0 next cycle; then in_valid=1 loads normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU issue (ID/EX) stage.
//   aluop_t   ALU operation code type
//   ridx_t    register index type
//   ALUOP_*   ALU operation encodings, ALUOP_NOP is the bubble opcode
//   REG_ZERO  index of the hard-wired zero register
// Optional feature macro used by the files importing this package: WB_FWD_EN
package alu_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 5;
    localparam int ALUOP_W   = 5;

    typedef logic [ALUOP_W-1:0]   aluop_t;
    typedef logic [REG_IDX_W-1:0] ridx_t;

    localparam aluop_t ALUOP_NOP = 5'h00;
    localparam aluop_t ALUOP_ADD = 5'h01;
    localparam aluop_t ALUOP_SUB = 5'h02;
    localparam aluop_t ALUOP_AND = 5'h03;
    localparam aluop_t ALUOP_OR  = 5'h04;
    localparam aluop_t ALUOP_XOR = 5'h05;
    localparam aluop_t ALUOP_SLT = 5'h06;
    localparam aluop_t ALUOP_SLL = 5'h07;
    localparam aluop_t ALUOP_SRL = 5'h08;
    localparam aluop_t ALUOP_SRA = 5'h09;
    localparam aluop_t ALUOP_LUI = 5'h0A;

    localparam ridx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: selects the value one ALU source operand should see.
//   idx, data            registered source index and regfile data
//   mem_wr_en/idx/data   EX/MEM result bus
//   wb_wr_en/idx/data    MEM/WB result bus (only used when WB_FWD_EN is defined)
//   fwd                  forwarded operand value
// Priority: zero register > EX/MEM > MEM/WB (WB_FWD_EN) > registered data.
module fwd_mux
    import alu_pkg::*;
#(
    parameter int W      = DATA_W,
    parameter int RIDX_W = REG_IDX_W
) (
    input  logic [RIDX_W-1:0] idx,
    input  logic [W-1:0]      data,
    input  logic              mem_wr_en,
    input  logic [RIDX_W-1:0] mem_idx,
    input  logic [W-1:0]      mem_data,
    input  logic              wb_wr_en,
    input  logic [RIDX_W-1:0] wb_idx,
    input  logic [W-1:0]      wb_data,
    output logic [W-1:0]      fwd
);

    logic is_zero;
    logic mem_hit;

    assign is_zero = (idx == RIDX_W'(REG_ZERO));
    assign mem_hit = mem_wr_en && (mem_idx == idx);

`ifdef WB_FWD_EN
    logic wb_hit;
    assign wb_hit = wb_wr_en && (wb_idx == idx);

    always_comb begin
        fwd = data;
        if (is_zero)
            fwd = '0;
        else if (mem_hit)
            fwd = mem_data;
        else if (wb_hit)
            fwd = wb_data;
    end
`else
    // Without the WB path the regfile is write-before-read, so the WB bus
    // carries nothing this stage needs.
    logic unused_wb;
    assign unused_wb = ^{wb_wr_en, wb_idx, wb_data};

    always_comb begin
        fwd = data;
        if (is_zero)
            fwd = '0;
        else if (mem_hit)
            fwd = mem_data;
    end
`endif

endmodule

// File: rtl/alu_issue.sv
// alu_issue: ID/EX pipeline stage feeding the ALU.
//   clk, rst            clock, synchronous active-high reset
//   stall, flush        hazard-unit hold / bubble controls (rst > flush > stall > load)
//   in_*                decoded instruction from the decode stage
//   mem_*               EX/MEM forwarding source
//   wb_*                MEM/WB forwarding source
//   A, B, ALUOp         ALU operands and operation
//   out_valid           stage holds a valid instruction
//   out_rd_idx          registered destination index
//   out_wr_en           registered write enable, gated by out_valid
// Macro WB_FWD_EN: enables MEM/WB forwarding and refresh of held operands
// during a stall. Without it the wb_* ports are ignored.
module alu_issue
    import alu_pkg::*;
#(
    parameter int W      = DATA_W,
    parameter int RIDX_W = REG_IDX_W,
    parameter int OP_W   = ALUOP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [RIDX_W-1:0] in_rs_idx,
    input  logic [RIDX_W-1:0] in_rt_idx,
    input  logic [W-1:0]      in_rs_data,
    input  logic [W-1:0]      in_rt_data,
    input  logic [W-1:0]      in_imm,
    input  logic              in_use_imm,
    input  logic [OP_W-1:0]   in_aluop,
    input  logic [RIDX_W-1:0] in_rd_idx,
    input  logic              in_wr_en,
    input  logic              mem_wr_en,
    input  logic [RIDX_W-1:0] mem_idx,
    input  logic [W-1:0]      mem_data,
    input  logic              wb_wr_en,
    input  logic [RIDX_W-1:0] wb_idx,
    input  logic [W-1:0]      wb_data,
    output logic [W-1:0]      A,
    output logic [W-1:0]      B,
    output logic [OP_W-1:0]   ALUOp,
    output logic              out_valid,
    output logic [RIDX_W-1:0] out_rd_idx,
    output logic              out_wr_en
);

    logic              valid_q;
    logic [RIDX_W-1:0] rs_idx_q;
    logic [RIDX_W-1:0] rt_idx_q;
    logic [W-1:0]      rs_data_q;
    logic [W-1:0]      rt_data_q;
    logic [W-1:0]      imm_q;
    logic              use_imm_q;
    logic [OP_W-1:0]   aluop_q;
    logic [RIDX_W-1:0] rd_idx_q;
    logic              wr_en_q;

    logic [W-1:0]      rs_fwd;
    logic [W-1:0]      rt_fwd;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rs_idx_q  <= '0;
            rt_idx_q  <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            aluop_q   <= OP_W'(ALUOP_NOP);
            rd_idx_q  <= '0;
            wr_en_q   <= 1'b0;
        end else if (flush) begin
            // A flush coinciding with a stall only kills the instruction;
            // the rest of the stage keeps its held contents.
            valid_q <= 1'b0;
            wr_en_q <= 1'b0;
            if (!stall)
                aluop_q <= OP_W'(ALUOP_NOP);
        end else if (stall) begin
`ifdef WB_FWD_EN
            // The WB result is only visible for one cycle; capture it into the
            // held operand so it survives after the writer retires.
            if (valid_q && wb_wr_en && (wb_idx != RIDX_W'(REG_ZERO))) begin
                if (wb_idx == rs_idx_q)
                    rs_data_q <= wb_data;
                if (wb_idx == rt_idx_q)
                    rt_data_q <= wb_data;
            end
`endif
        end else begin
            valid_q   <= in_valid;
            rs_idx_q  <= in_rs_idx;
            rt_idx_q  <= in_rt_idx;
            rs_data_q <= in_rs_data;
            rt_data_q <= in_rt_data;
            imm_q     <= in_imm;
            use_imm_q <= in_use_imm;
            aluop_q   <= in_valid ? in_aluop : OP_W'(ALUOP_NOP);
            rd_idx_q  <= in_rd_idx;
            wr_en_q   <= in_valid && in_wr_en;
        end
    end

    fwd_mux #(.W(W), .RIDX_W(RIDX_W)) u_fwd_rs (
        .idx       (rs_idx_q),
        .data      (rs_data_q),
        .mem_wr_en (mem_wr_en),
        .mem_idx   (mem_idx),
        .mem_data  (mem_data),
        .wb_wr_en  (wb_wr_en),
        .wb_idx    (wb_idx),
        .wb_data   (wb_data),
        .fwd       (rs_fwd)
    );

    fwd_mux #(.W(W), .RIDX_W(RIDX_W)) u_fwd_rt (
        .idx       (rt_idx_q),
        .data      (rt_data_q),
        .mem_wr_en (mem_wr_en),
        .mem_idx   (mem_idx),
        .mem_data  (mem_data),
        .wb_wr_en  (wb_wr_en),
        .wb_idx    (wb_idx),
        .wb_data   (wb_data),
        .fwd       (rt_fwd)
    );

    // The immediate is a decode-time constant and never takes a forward.
    assign A          = rs_fwd;
    assign B          = use_imm_q ? imm_q : rt_fwd;
    assign ALUOp      = aluop_q;
    assign out_valid  = valid_q;
    assign out_rd_idx = rd_idx_q;
    assign out_wr_en  = wr_en_q && valid_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and randomized checks of alu_issue against a
// record-level model of the held instruction and the forwarding rules.
// Honours WB_FWD_EN the same way as the design.
module tb_alu_issue;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [4:0]  in_rs_idx;
    logic [4:0]  in_rt_idx;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [4:0]  in_aluop;
    logic [4:0]  in_rd_idx;
    logic        in_wr_en;
    logic        mem_wr_en;
    logic [4:0]  mem_idx;
    logic [31:0] mem_data;
    logic        wb_wr_en;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  ALUOp;
    logic        out_valid;
    logic [4:0]  out_rd_idx;
    logic        out_wr_en;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic        useImm;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic        wr;
    } held_t;

    held_t held;

    alu_issue dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_rs_idx  (in_rs_idx),
        .in_rt_idx  (in_rt_idx),
        .in_rs_data (in_rs_data),
        .in_rt_data (in_rt_data),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .in_aluop   (in_aluop),
        .in_rd_idx  (in_rd_idx),
        .in_wr_en   (in_wr_en),
        .mem_wr_en  (mem_wr_en),
        .mem_idx    (mem_idx),
        .mem_data   (mem_data),
        .wb_wr_en   (wb_wr_en),
        .wb_idx     (wb_idx),
        .wb_data    (wb_data),
        .A          (A),
        .B          (B),
        .ALUOp      (ALUOp),
        .out_valid  (out_valid),
        .out_rd_idx (out_rd_idx),
        .out_wr_en  (out_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value an instruction reading register idx should see right now.
    function automatic logic [31:0] expOperand(input logic [4:0] idx, input logic [31:0] regVal);
        if (idx == 5'd0)
            return 32'h0;
        if (mem_wr_en && mem_idx == idx)
            return mem_data;
`ifdef WB_FWD_EN
        if (wb_wr_en && wb_idx == idx)
            return wb_data;
`endif
        return regVal;
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One rising edge; the model takes the same edge from the same inputs.
    task automatic applyStimulus();
        @(posedge clk);
        if (rst) begin
            held = '{v: 1'b0, rs: 5'd0, rt: 5'd0, rsd: 32'h0, rtd: 32'h0, imm: 32'h0,
                     useImm: 1'b0, op: 5'd0, rd: 5'd0, wr: 1'b0};
        end else if (flush) begin
            held.v  = 1'b0;
            held.wr = 1'b0;
            if (!stall)
                held.op = 5'd0;
        end else if (stall) begin
`ifdef WB_FWD_EN
            if (held.v && wb_wr_en && wb_idx != 5'd0) begin
                if (wb_idx == held.rs) held.rsd = wb_data;
                if (wb_idx == held.rt) held.rtd = wb_data;
            end
`endif
        end else begin
            held = '{v: in_valid, rs: in_rs_idx, rt: in_rt_idx, rsd: in_rs_data,
                     rtd: in_rt_data, imm: in_imm, useImm: in_use_imm, op: in_aluop,
                     rd: in_rd_idx, wr: in_valid && in_wr_en};
        end
    endtask

    task automatic checkOutput(input string tag, input bit checkAB);
        #1;
        chk({tag, ".valid"}, 32'(out_valid), 32'(held.v));
        chk({tag, ".wr_en"}, 32'(out_wr_en), 32'(held.v && held.wr));
        if (held.v) begin
            chk({tag, ".aluop"}, 32'(ALUOp), 32'(held.op));
            chk({tag, ".rd"}, 32'(out_rd_idx), 32'(held.rd));
        end
        if (held.v || checkAB) begin
            chk({tag, ".A"}, A, expOperand(held.rs, held.rsd));
            chk({tag, ".B"}, B, held.useImm ? held.imm : expOperand(held.rt, held.rtd));
        end
    endtask

    task automatic clearFwd();
        mem_wr_en = 1'b0; mem_idx = 5'd0; mem_data = 32'h0;
        wb_wr_en  = 1'b0; wb_idx  = 5'd0; wb_data  = 32'h0;
    endtask

    task automatic setLoad(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsd,
                           input logic [31:0] rtd, input logic useImm, input logic [31:0] imm,
                           input logic [4:0] op, input logic [4:0] rd);
        in_valid = 1'b1; in_rs_idx = rs; in_rt_idx = rt; in_rs_data = rsd; in_rt_data = rtd;
        in_use_imm = useImm; in_imm = imm; in_aluop = op; in_rd_idx = rd; in_wr_en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        setLoad(5'd7, 5'd8, 32'h1234, 32'h5678, 1'b0, 32'h9, 5'h0A, 5'd9);
        clearFwd();

        // Reset wins over a valid incoming instruction.
        applyStimulus();
        checkOutput("reset", 1'b1);
        chk("reset.A0", A, 32'h0);
        chk("reset.aluop0", 32'(ALUOp), 32'h0);

        // Plain load, no forwarding.
        rst = 1'b0;
        setLoad(5'd3, 5'd4, 32'h11, 32'h22, 1'b0, 32'h0, 5'h01, 5'd5);
        applyStimulus();
        checkOutput("load", 1'b0);
        chk("load.A", A, 32'h11);
        chk("load.B", B, 32'h22);

        // MEM and WB both match rs: MEM wins, zero-cycle path.
        in_valid = 1'b0;
        stall = 1'b1;
        mem_wr_en = 1'b1; mem_idx = 5'd3; mem_data = 32'hAAAA;
        wb_wr_en  = 1'b1; wb_idx  = 5'd3; wb_data  = 32'hBBBB;
        checkOutput("memwins", 1'b0);
        chk("memwins.A", A, 32'hAAAA);
        clearFwd();
        stall = 1'b0;

        // Zero register never forwards; immediate is never forwarded.
        setLoad(5'd0, 5'd4, 32'h99, 32'h33, 1'b1, 32'h7, 5'h02, 5'd6);
        mem_wr_en = 1'b1; mem_idx = 5'd0; mem_data = 32'hFFFF;
        applyStimulus();
        checkOutput("zero", 1'b0);
        chk("zero.A", A, 32'h0);
        mem_idx = 5'd4; wb_wr_en = 1'b1; wb_idx = 5'd4; wb_data = 32'h44;
        checkOutput("immfwd", 1'b0);
        chk("immfwd.B", B, 32'h7);
        clearFwd();

        // Stall three cycles; a WB write to rt lands during the first one.
        setLoad(5'd3, 5'd4, 32'h11, 32'h22, 1'b0, 32'h0, 5'h03, 5'd5);
        applyStimulus();
        checkOutput("preStall", 1'b0);
        stall = 1'b1;
        in_rt_data = 32'hDEAD; in_rs_data = 32'hBEEF;
        wb_wr_en = 1'b1; wb_idx = 5'd4; wb_data = 32'h55;
        applyStimulus();
        clearFwd();
        checkOutput("stall1", 1'b0);
        applyStimulus();
        checkOutput("stall2", 1'b0);
        applyStimulus();
        checkOutput("stall3", 1'b0);
        stall = 1'b0;
`ifdef WB_FWD_EN
        chk("stallRefresh.B", B, 32'h55);
`else
        chk("stallRefresh.B", B, 32'h22);
`endif
        chk("stallHold.A", A, 32'h11);

        // Flush together with stall kills the held instruction.
        flush = 1'b1; stall = 1'b1;
        applyStimulus();
        checkOutput("flushStall", 1'b0);
        chk("flushStall.valid", 32'(out_valid), 32'h0);
        flush = 1'b0; stall = 1'b0;
        setLoad(5'd1, 5'd2, 32'hC0DE, 32'hF00D, 1'b0, 32'h0, 5'h04, 5'd10);
        applyStimulus();
        checkOutput("afterFlush", 1'b0);
        chk("afterFlush.A", A, 32'hC0DE);

        // Randomized traffic over a small register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 39) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            in_valid   = ($urandom_range(0, 4) != 0);
            in_rs_idx  = 5'($urandom_range(0, 7));
            in_rt_idx  = 5'($urandom_range(0, 7));
            in_rs_data = $urandom;
            in_rt_data = $urandom;
            in_imm     = $urandom;
            in_use_imm = 1'($urandom_range(0, 1));
            in_aluop   = 5'($urandom_range(0, 31));
            in_rd_idx  = 5'($urandom_range(0, 31));
            in_wr_en   = 1'($urandom_range(0, 1));
            mem_wr_en  = 1'($urandom_range(0, 1));
            mem_idx    = 5'($urandom_range(0, 7));
            mem_data   = $urandom;
            wb_wr_en   = 1'($urandom_range(0, 1));
            wb_idx     = 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            applyStimulus();
            checkOutput("rand", 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
